// File: rtl/avalon_ram_responder_if.sv
// Avalon-style memory bus between the CPU control path (master) and a memory responder (slave).
interface avalon_ram_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, bus_error
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, bus_error
  );
endinterface

// File: rtl/avalon_ram_responder.sv
module avalon_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input logic                    clk,
  input logic                    reset,
  avalon_ram_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             req, wait_o, done;
  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] index;

  assign req    = bus.read | bus.write;
  assign wait_o = reset | (req & (cnt_q != 4'(WAIT_CYCLES)));
  assign done   = req & ~wait_o;
  assign offset = bus.address - BASE_ADDR;
  assign hit    = offset < 32'(DEPTH_WORDS * 4);
  assign index  = offset[IDX_W+1:2];

  assign bus.waitrequest = wait_o;
  assign bus.readdata    = rdata_q;
  assign bus.bus_error   = err_q;

  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (!req) begin
      cnt_d = '0;
    end else if (wait_o) begin
      cnt_d = cnt_q + 4'd1;
      if (bus.read && !bus.write && cnt_q == 4'(WAIT_CYCLES - 1))
        rdata_d = hit ? mem[index] : 32'h0;
    end else begin
      cnt_d = '0;
      if (!hit || (bus.read && bus.write)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (done && bus.write && hit) begin
      for (int n = 0; n < 4; n++)
        if (bus.byteenable[n]) mem[index][8*n +: 8] <= bus.writedata[8*n +: 8];
    end
  end
endmodule

// File: tb/tb_avalon_ram_responder.sv
// Directed checks of the Avalon RAM responder: timing, byte lanes, misses, aborts and reset.
module tb_avalon_ram_responder;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  avalon_ram_responder_if bus ();

  avalon_ram_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(2), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input bit last,
                      output logic [31:0] rdata, output int waits);
    bus.read = rd; bus.write = wr; bus.address = addr;
    bus.byteenable = be; bus.writedata = wd;
    waits = 0;
    rdata = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        rdata = bus.readdata;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    if (last) begin bus.read = 1'b0; bus.write = 1'b0; end
  endtask

  logic [31:0] rd;
  int          w;

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = BASE;
    bus.byteenable = 4'h0; bus.writedata = '0;
    // Reset state, with a request present to show waitrequest is forced high.
    @(posedge clk); #1;
    bus.read = 1'b1;
    @(negedge clk);
    chk("reset_wait", {31'b0, bus.waitrequest}, 32'd1);
    chk("reset_rdata", bus.readdata, 32'h0);
    chk("reset_err", {31'b0, bus.bus_error}, 32'd0);
    @(posedge clk); #1;
    bus.read = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_wait", {31'b0, bus.waitrequest}, 32'd0);
    @(posedge clk); #1;

    // Word 0 load and read-back.
    xact(0, 1, BASE, 4'hF, 32'h3C080001, 1, rd, w);
    chk("wr0_waits", w, 32'd2);
    xact(1, 0, BASE, 4'h0, 32'h0, 1, rd, w);
    chk("rd0_waits", w, 32'd2);
    chk("rd0_data", rd, 32'h3C080001);
    chk("rd0_err", {31'b0, bus.bus_error}, 32'd0);

    // Byte lanes.
    xact(0, 1, BASE + 8, 4'hF, 32'hAABBCCDD, 1, rd, w);
    xact(0, 1, BASE + 8, 4'b0001, 32'h00000011, 1, rd, w);
    xact(1, 0, BASE + 8, 4'h0, 32'h0, 1, rd, w);
    chk("be0001", rd, 32'hAABBCC11);
    xact(0, 1, BASE + 4, 4'hF, 32'h0, 1, rd, w);
    xact(0, 1, BASE + 4, 4'b1100, 32'h12345678, 1, rd, w);
    xact(1, 0, BASE + 4, 4'h0, 32'h0, 1, rd, w);
    chk("be1100", rd, 32'h12340000);
    xact(0, 1, BASE + 4, 4'b0000, 32'hFFFFFFFF, 1, rd, w);
    xact(1, 0, BASE + 4, 4'h0, 32'h0, 1, rd, w);
    chk("be0000", rd, 32'h12340000);
    chk("be0000_err", {31'b0, bus.bus_error}, 32'd0);

    // Back-to-back write then read of the same word, request held high.
    xact(0, 1, BASE + 16, 4'hF, 32'hCAFEF00D, 0, rd, w);
    xact(1, 0, BASE + 16, 4'h0, 32'h0, 1, rd, w);
    chk("b2b_waits", w, 32'd2);
    chk("b2b_data", rd, 32'hCAFEF00D);

    // Misses below and above the window; error is sticky.
    xact(1, 0, BASE - 4, 4'h0, 32'h0, 1, rd, w);
    chk("miss_lo_waits", w, 32'd2);
    chk("miss_lo_data", rd, 32'h0);
    chk("miss_lo_err", {31'b0, bus.bus_error}, 32'd1);
    xact(1, 0, BASE + 8, 4'h0, 32'h0, 1, rd, w);
    chk("sticky_data", rd, 32'hAABBCC11);
    chk("sticky_err", {31'b0, bus.bus_error}, 32'd1);
    xact(1, 0, BASE + 32'd4096, 4'h0, 32'h0, 1, rd, w);
    chk("miss_hi_waits", w, 32'd2);
    chk("miss_hi_data", rd, 32'h0);

    // Reset clears the error; read+write together is a write that flags an error.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("rst_clr_err", {31'b0, bus.bus_error}, 32'd0);
    xact(1, 1, BASE, 4'hF, 32'hDEADBEEF, 1, rd, w);
    chk("rw_err", {31'b0, bus.bus_error}, 32'd1);
    xact(1, 0, BASE, 4'h0, 32'h0, 1, rd, w);
    chk("rw_data", rd, 32'hDEADBEEF);

    // Write dropped after one wait cycle commits nothing.
    xact(0, 1, BASE + 12, 4'hF, 32'h0, 1, rd, w);
    bus.write = 1'b1; bus.address = BASE + 12; bus.byteenable = 4'hF;
    bus.writedata = 32'h55555555;
    @(posedge clk); #1; bus.write = 1'b0;
    @(posedge clk); #1;
    xact(1, 0, BASE + 12, 4'h0, 32'h0, 1, rd, w);
    chk("abort_waits", w, 32'd2);
    chk("abort_data", rd, 32'h0);

    // Reset in cycle 1 of a write commits nothing.
    bus.write = 1'b1; bus.writedata = 32'h77777777;
    @(posedge clk); #1; reset = 1'b1; bus.write = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait", {31'b0, bus.waitrequest}, 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    xact(1, 0, BASE + 12, 4'h0, 32'h0, 1, rd, w);
    chk("rst_mid_waits", w, 32'd2);
    chk("rst_mid_data", rd, 32'h0);

    // Request held across reset restarts from cycle 0 after release.
    bus.read = 1'b1; bus.address = BASE + 8;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    xact(1, 0, BASE + 8, 4'h0, 32'h0, 1, rd, w);
    chk("rst_hold_waits", w, 32'd2);
    chk("rst_hold_data", rd, 32'hAABBCC11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
